// File: rtl/kgp_pkg.sv
`default_nettype none
// ============================================================================
// Package : kgp_pkg
// Shared widths and the writeback entry type for the KGP-RISC register bank.
// Rev     : 1.0
// ============================================================================
package kgp_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] dr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_fifo
// Generic in-order circular FIFO that also exports a per-slot key/valid view.
// Rev    : 1.0
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37,
    parameter int KEY_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DEPTH*KEY_W-1:0] o_keys,
    output logic [DEPTH-1:0]       o_valid
);
    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW:0]   C_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == C_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [PW-1:0] w_off;
        assign w_off                     = PW'(i) - r_rd_ptr;
        assign o_valid[i]                = ({1'b0, w_off} < r_count);
        assign o_keys[i*KEY_W +: KEY_W]  = r_mem[i][WIDTH-1 -: KEY_W];
    end
endmodule
`default_nettype wire

// File: rtl/kgp_writeback.sv
`default_nettype none
// ============================================================================
// Module : kgp_writeback
// ALU/load result arbiter and writeback queue feeding the register bank port.
// Rev    : 1.0
// ============================================================================
module kgp_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = kgp_pkg::DATA_W,
    parameter int ADDR_W = kgp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_en,
    output logic              write,
    output logic [ADDR_W-1:0] dr,
    output logic [DATA_W-1:0] wrData,
    output logic [31:0]       pend_mask,
    output logic              full,
    output logic              empty
);
    localparam int C_NREGS = kgp_pkg::NUM_REGS;
    localparam int C_ENT_W = ADDR_W + DATA_W;

    logic                      w_full;
    logic                      w_empty;
    logic [C_ENT_W-1:0]        w_head;
    logic [DEPTH*ADDR_W-1:0]   w_keys;
    logic [DEPTH-1:0]          w_valid;
    logic                      w_mem_hs;
    logic                      w_alu_hs;
    logic                      w_push;
    logic [ADDR_W-1:0]         w_push_dr;
    logic [DATA_W-1:0]         w_push_data;
    logic [C_NREGS-1:0]        w_pend;

    // Loads win arbitration; an ALU result waits while a load is offered.
    assign mem_ready   = !w_full;
    assign alu_ready   = !w_full && !mem_valid;
    assign w_mem_hs    = mem_valid && mem_ready;
    assign w_alu_hs    = alu_valid && alu_ready;
    assign w_push_dr   = w_mem_hs ? mem_dr   : alu_dr;
    assign w_push_data = w_mem_hs ? mem_data : alu_data;
    assign w_push      = (w_mem_hs || w_alu_hs) && (w_push_dr != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (C_ENT_W),
        .KEY_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (write),
        .i_din   ({w_push_dr, w_push_data}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_keys  (w_keys),
        .o_valid (w_valid)
    );

    assign write  = !w_empty && wb_en;
    assign dr     = w_head[C_ENT_W-1 -: ADDR_W];
    assign wrData = w_head[DATA_W-1:0];
    assign full   = w_full;
    assign empty  = w_empty;

    // r0 is never enqueued, so bit 0 is left clear by starting at j=1.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 1; j < C_NREGS; j++) begin
                if (w_valid[i] && (w_keys[i*ADDR_W +: ADDR_W] == ADDR_W'(j))) begin
                    w_pend[j] = 1'b1;
                end
            end
        end
    end

    assign pend_mask = w_pend;
endmodule
`default_nettype wire
